// File: rtl/fifo_pixel_unpack.sv
// fifo_pixel_unpack: drain stage behind the line FIFO.
// This stage pops DATA_WIDTH-bit words from the FIFO read port, which returns ff_rdat/ff_rvld
// one cycle after ff_rden. It splits each word into PIX_WIDTH-bit pixels, LSB pixel first, and
// offers them on a valid/ready handshake.
// One word is prefetched into a second register, so a pixel is available every cycle the
// consumer is ready, provided the FIFO keeps up.
// Optional feature: define UNDERFLOW_CNT_EN to build the saturating underflow counter.
// Without it, underflow_cnt is tied to zero. The underflow pulse is present in both builds.
module fifo_pixel_unpack #(
   parameter int DATA_WIDTH = 32,
   parameter int PIX_WIDTH  = 8,
   parameter int IDX_WIDTH  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  ff_rden,
   input  logic [DATA_WIDTH-1:0] ff_rdat,
   input  logic                  ff_rvld,
   input  logic                  ff_empty,
   input  logic                  flush,
   output logic [PIX_WIDTH-1:0]  pix_dat,
   output logic                  pix_vld,
   input  logic                  pix_rdy,
   output logic                  underflow,
   output logic [15:0]           underflow_cnt
);

   localparam int PIX_PER_WORD = DATA_WIDTH / PIX_WIDTH;
   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(PIX_PER_WORD - 1);

   // Word being unpacked
   logic [DATA_WIDTH-1:0] cur_word_q, cur_word_d;
   logic                  cur_vld_q,  cur_vld_d;
   // Prefetched word waiting behind cur
   logic [DATA_WIDTH-1:0] nxt_word_q, nxt_word_d;
   logic                  nxt_vld_q,  nxt_vld_d;
   // Position of the presented pixel inside cur
   logic [IDX_WIDTH-1:0]  pix_idx_q,  pix_idx_d;
   // A read was issued last cycle, so its data returns this cycle
   logic                  rd_pend_q,  rd_pend_d;
   // The next returning word belongs to data already flushed
   logic                  drop_q,     drop_d;
   // At least one pixel has been transferred since rst/flush
   logic                  started_q,  started_d;
   logic                  underflow_q, underflow_d;

   logic xfer;
   logic last_xfer;
   logic capture;

   assign xfer      = cur_vld_q & pix_rdy;
   assign last_xfer = xfer & (pix_idx_q == LAST_IDX);
   // A returning word is kept unless it belongs to a flushed read or a flush is active now
   assign capture   = ff_rvld & ~drop_q & ~flush;

   // Issue a read only when nothing is in flight and the prefetch slot is free
   assign ff_rden = ~ff_empty & ~rd_pend_q & ~nxt_vld_q & ~flush & ~rst;

   assign pix_vld   = cur_vld_q;
   assign underflow = underflow_q;

   // Select the current pixel out of cur, LSB pixel first
   always_comb begin
      pix_dat = '0;
      for (int i = 0; i < PIX_PER_WORD; i++) begin
         if (pix_idx_q == IDX_WIDTH'(i)) begin
            pix_dat = cur_word_q[i*PIX_WIDTH +: PIX_WIDTH];
         end
      end
   end

   // Next-state logic for the unpack registers, the read tracking and the underflow detector
   always_comb begin
      // NOTE: every signal gets its hold value first, so no branch can leave one unassigned (no latches).
      cur_word_d  = cur_word_q;
      cur_vld_d   = cur_vld_q;
      nxt_word_d  = nxt_word_q;
      nxt_vld_d   = nxt_vld_q;
      pix_idx_d   = pix_idx_q;
      drop_d      = drop_q;
      started_d   = started_q;
      rd_pend_d   = ff_rden;
      underflow_d = started_q & pix_rdy & ~cur_vld_q;

      // A word that belonged to flushed data is discarded here, which consumes the drop marker
      if (ff_rvld && drop_q) begin
         drop_d = 1'b0;
      end

      if (last_xfer) begin
         // cur is finished: refill it from nxt first, then from the word arriving now
         pix_idx_d = '0;
         if (nxt_vld_q) begin
            cur_word_d = nxt_word_q;
            nxt_vld_d  = 1'b0;
            if (capture) begin
               nxt_word_d = ff_rdat;
               nxt_vld_d  = 1'b1;
            end
         end else if (capture) begin
            cur_word_d = ff_rdat;
         end else begin
            cur_vld_d = 1'b0;
         end
      end else begin
         if (xfer) begin
            pix_idx_d = pix_idx_q + IDX_WIDTH'(1);
         end
         if (capture) begin
            if (!cur_vld_q) begin
               cur_word_d = ff_rdat;
               cur_vld_d  = 1'b1;
            end else begin
               nxt_word_d = ff_rdat;
               nxt_vld_d  = 1'b1;
            end
         end
      end

      if (xfer) begin
         started_d = 1'b1;
      end

      // A flush clears all held data in the same edge.
      // A read still in flight is marked so that its word is thrown away when it arrives.
      // A word that arrives during the flush cycle is already discarded by capture.
      if (flush) begin
         cur_word_d  = '0;
         cur_vld_d   = 1'b0;
         nxt_word_d  = '0;
         nxt_vld_d   = 1'b0;
         pix_idx_d   = '0;
         started_d   = 1'b0;
         underflow_d = 1'b0;
         drop_d      = (drop_q | rd_pend_q) & ~ff_rvld;
      end
   end

   // State register with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the data words are reset as well, because pix_dat must read zero after reset.
         cur_word_q  <= '0;
         cur_vld_q   <= 1'b0;
         nxt_word_q  <= '0;
         nxt_vld_q   <= 1'b0;
         pix_idx_q   <= '0;
         rd_pend_q   <= 1'b0;
         drop_q      <= 1'b0;
         started_q   <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments, so every register samples the pre-edge values.
         cur_word_q  <= cur_word_d;
         cur_vld_q   <= cur_vld_d;
         nxt_word_q  <= nxt_word_d;
         nxt_vld_q   <= nxt_vld_d;
         pix_idx_q   <= pix_idx_d;
         rd_pend_q   <= rd_pend_d;
         drop_q      <= drop_d;
         started_q   <= started_d;
         underflow_q <= underflow_d;
      end
   end

`ifdef UNDERFLOW_CNT_EN
   logic [15:0] underflow_cnt_q, underflow_cnt_d;

   // Count underflow pulses, saturating at all-ones. A flush does not clear the count.
   always_comb begin
      underflow_cnt_d = underflow_cnt_q;
      if (underflow_q && (underflow_cnt_q != 16'hFFFF)) begin
         underflow_cnt_d = underflow_cnt_q + 16'd1;
      end
   end

   // Underflow counter register, cleared only by rst
   always_ff @(posedge clk) begin
      if (rst) begin
         underflow_cnt_q <= 16'h0;
      end else begin
         underflow_cnt_q <= underflow_cnt_d;
      end
   end

   assign underflow_cnt = underflow_cnt_q;
`else
   assign underflow_cnt = 16'h0;
`endif

endmodule
